// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: instruction field widths, the B opcode and the fetch FSM states.
package legv8_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 11;

  localparam logic [5:0] OP_B = 6'b000101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC computation for the fetch stage: sequential pc+4, or the unconditional B target
// when FETCH_EARLY_B_EN is defined.
module fetch_pc_next
  import legv8_pkg::*;
#(
  parameter int PC_WIDTH = 64
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [INSTR_W-1:0]  instr,
  output logic [PC_WIDTH-1:0] pc_next
);

  logic [PC_WIDTH-1:0] pc_seq;

  assign pc_seq = pc + PC_WIDTH'(4);

`ifdef FETCH_EARLY_B_EN
  logic signed [PC_WIDTH-1:0] b_off;

  // imm26 is a word offset: sign-extend and scale to bytes
  assign b_off   = {{(PC_WIDTH-28){instr[25]}}, instr[25:0], 2'b00};
  assign pc_next = (instr[31:26] == OP_B) ? pc + $unsigned(b_off) : pc_seq;
`else
  logic unused_instr;

  assign unused_instr = ^instr;
  assign pc_next      = pc_seq;
`endif

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage: PC, imem request/ack handshake, one-entry skid buffer and IF/ID.
// Optional early B resolution is enabled with the FETCH_EARLY_B_EN macro.
module fetch_stage
  import legv8_pkg::*;
#(
  parameter int                   PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_W-1:0]   imem_rdata,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic                 if_id_valid,
  output logic [PC_WIDTH-1:0]  if_id_pc,
  output logic [INSTR_W-1:0]   if_id_instr,
  output logic [OPCODE_W-1:0]  if_id_opcode
);

  fetch_state_e          state;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_next;
  logic [PC_WIDTH-1:0]   target;
  logic [INSTR_W-1:0]    skid_instr;
  logic [PC_WIDTH-1:0]   skid_pc;
  logic                  fire;
  logic                  if_id_free;

  assign fire       = imem_req & imem_ack;
  assign if_id_free = !stall || !if_id_valid;
  assign target     = branch_target & ~PC_WIDTH'(3);

  fetch_pc_next #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next (
    .pc      (pc),
    .instr   (imem_rdata),
    .pc_next (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      if_id_valid  <= 1'b0;
      if_id_pc     <= '0;
      if_id_instr  <= '0;
      if_id_opcode <= '0;
    end else if (branch_taken) begin
      pc          <= target;
      if_id_valid <= 1'b0;
      // An unacked request must finish at its original address before the target goes out
      if (imem_req && !imem_ack) begin
        state <= ST_DISCARD;
      end else begin
        state     <= ST_FETCH;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        ST_FETCH: begin
          if (fire) begin
            pc        <= pc_next;
            imem_addr <= pc_next;
            if (if_id_free) begin
              if_id_valid  <= 1'b1;
              if_id_pc     <= pc;
              if_id_instr  <= imem_rdata;
              if_id_opcode <= imem_rdata[31:21];
            end else begin
              state    <= ST_HOLD;
              imem_req <= 1'b0;
            end
          end else if (!stall) begin
            if_id_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state        <= ST_FETCH;
            imem_req     <= 1'b1;
            if_id_valid  <= 1'b1;
            if_id_pc     <= skid_pc;
            if_id_instr  <= skid_instr;
            if_id_opcode <= skid_instr[31:21];
          end
        end
        ST_DISCARD: begin
          if (!stall) if_id_valid <= 1'b0;
          if (fire) begin
            state     <= ST_FETCH;
            imem_addr <= pc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Skid data carries no reset; it is only read in HOLD, which is entered together with this write
  always_ff @(posedge clk) begin
    if (state == ST_FETCH && fire && !if_id_free) begin
      skid_instr <= imem_rdata;
      skid_pc    <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a variable-latency instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  int          lat;
  int          wcnt;
  int          n_checks;
  int          n_errors;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [10:0] if_id_opcode;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_valid;
  logic [63:0] w_pc;
  logic [31:0] unused_w_instr;
  logic [10:0] unused_w_opcode;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h8B02_0020;
      64'h4:   return 32'hF840_0041;
      64'h40:  return 32'h17FF_FFFE;
      default: return {16'h9100, a[15:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign imem_ack   = imem_req && (wcnt >= lat);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wcnt <= 0;
    else                              wcnt <= wcnt + 1;
  end

  fetch_stage #(.PC_WIDTH(64), .RESET_PC(64'h0)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_opcode  (if_id_opcode)
  );

  fetch_stage #(.PC_WIDTH(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (1'b1),
    .imem_rdata    (32'h9100_0000),
    .stall         (1'b0),
    .branch_taken  (1'b0),
    .branch_target (64'h0),
    .if_id_valid   (w_valid),
    .if_id_pc      (w_pc),
    .if_id_instr   (unused_w_instr),
    .if_id_opcode  (unused_w_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    lat           = 0;
    tick();
    tick();
    check_eq("rst_req",    64'(imem_req), 64'h0);
    check_eq("rst_addr",   imem_addr, 64'h0);
    check_eq("rst_valid",  64'(if_id_valid), 64'h0);
    check_eq("rst_opcode", 64'(if_id_opcode), 64'h0);
    check_eq("rst_pc",     if_id_pc, 64'h0);
    check_eq("rst_w_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    rst = 1'b0;

    // Zero-wait streaming from reset; the wrap instance runs alongside
    tick();
    check_eq("zw_req0",  64'(imem_req), 64'h1);
    check_eq("zw_addr0", imem_addr, 64'h0);
    check_eq("zw_val0",  64'(if_id_valid), 64'h0);
    check_eq("wrap_addr0", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_req0",  64'(w_req), 64'h1);
    tick();
    check_eq("zw_addr1", imem_addr, 64'h4);
    check_eq("zw_val1",  64'(if_id_valid), 64'h1);
    check_eq("zw_op1",   64'(if_id_opcode), 64'h458);
    check_eq("zw_pc1",   if_id_pc, 64'h0);
    check_eq("wrap_addr1", w_addr, 64'h0);
    check_eq("wrap_pc1",   w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_val1",  64'(w_valid), 64'h1);
    tick();
    check_eq("zw_addr2", imem_addr, 64'h8);
    check_eq("zw_op2",   64'(if_id_opcode), 64'h7C2);
    check_eq("zw_pc2",   if_id_pc, 64'h4);

    // Three-cycle ack latency at address 8
    lat = 2;
    tick();
    check_eq("lat_addr_a", imem_addr, 64'h8);
    check_eq("lat_val_a",  64'(if_id_valid), 64'h0);
    tick();
    check_eq("lat_addr_b", imem_addr, 64'h8);
    check_eq("lat_val_b",  64'(if_id_valid), 64'h0);
    tick();
    check_eq("lat_val_c",  64'(if_id_valid), 64'h1);
    check_eq("lat_pc_c",   if_id_pc, 64'h8);
    check_eq("lat_ins_c",  64'(if_id_instr), 64'h9100_0008);
    check_eq("lat_addr_c", imem_addr, 64'hC);

    // Four stall cycles with IF/ID valid: word at 0xC parks in the skid buffer
    lat   = 0;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("stl_pc",    if_id_pc, 64'h8);
      check_eq("stl_ins",   64'(if_id_instr), 64'h9100_0008);
      check_eq("stl_valid", 64'(if_id_valid), 64'h1);
      check_eq("stl_req",   64'(imem_req), 64'h0);
    end
    stall = 1'b0;
    tick();
    check_eq("rel_pc",   if_id_pc, 64'hC);
    check_eq("rel_ins",  64'(if_id_instr), 64'h9100_000C);
    check_eq("rel_req",  64'(imem_req), 64'h1);
    check_eq("rel_addr", imem_addr, 64'h10);
    tick();
    check_eq("rel_pc2",  if_id_pc, 64'h10);
    check_eq("rel_val2", 64'(if_id_valid), 64'h1);

    // Redirect coinciding with an ack: data at 0x14 dropped, target 0x103 aligned to 0x100
    branch_taken  = 1'b1;
    branch_target = 64'h103;
    tick();
    branch_taken = 1'b0;
    check_eq("br_addr",  imem_addr, 64'h100);
    check_eq("br_valid", 64'(if_id_valid), 64'h0);
    check_eq("br_req",   64'(imem_req), 64'h1);
    tick();
    check_eq("br_pc",    if_id_pc, 64'h100);
    check_eq("br_val2",  64'(if_id_valid), 64'h1);
    check_eq("br_addr2", imem_addr, 64'h104);

    // Redirect behind an unacked request at 0x104
    lat = 3;
    tick();
    branch_taken  = 1'b1;
    branch_target = 64'h103;
    tick();
    branch_taken = 1'b0;
    check_eq("dis_addr_a", imem_addr, 64'h104);
    check_eq("dis_req_a",  64'(imem_req), 64'h1);
    check_eq("dis_val_a",  64'(if_id_valid), 64'h0);
    tick();
    check_eq("dis_addr_b", imem_addr, 64'h104);
    tick();
    check_eq("dis_addr_c", imem_addr, 64'h100);
    check_eq("dis_val_c",  64'(if_id_valid), 64'h0);
    lat = 0;
    tick();
    check_eq("dis_pc_d",   if_id_pc, 64'h100);
    check_eq("dis_val_d",  64'(if_id_valid), 64'h1);

    // B at 0x40 with imm26 = -2
    branch_taken  = 1'b1;
    branch_target = 64'h40;
    tick();
    branch_taken = 1'b0;
    check_eq("b_addr0", imem_addr, 64'h40);
    tick();
    check_eq("b_ins",   64'(if_id_instr), 64'h17FF_FFFE);
    check_eq("b_op",    64'(if_id_opcode), 64'h0BF);
`ifdef FETCH_EARLY_B_EN
    check_eq("b_next",  imem_addr, 64'h38);
`else
    check_eq("b_next",  imem_addr, 64'h44);
`endif
    tick();
`ifdef FETCH_EARLY_B_EN
    check_eq("b_pc2",   if_id_pc, 64'h38);
`else
    check_eq("b_pc2",   if_id_pc, 64'h44);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the LEGv8 pipeline: owns the PC, drives a variable-latency instruction-memory request/ack interface and fills the IF/ID register. Its `if_id_opcode` output feeds the decode-stage main controller directly. The stage also honours decode stalls and execute-stage branch redirects.

## Interface
- `PC_WIDTH`, 64: PC and address width.
- `RESET_PC`, 0: first fetch address; must be 4-byte aligned.
- `clk` in 1: the only clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request; held until acknowledged.
- `imem_addr` out PC_WIDTH: fetch address; stable while `imem_req`=1.
- `imem_ack` in 1: transaction completes on an edge with `imem_req`&`imem_ack`.
- `imem_rdata` in 32: instruction word, valid in the ack cycle.
- `stall` in 1: decode cannot accept; hold IF/ID.
- `branch_taken` in 1: one-cycle redirect pulse from EX.
- `branch_target` in PC_WIDTH: redirect address; bits [1:0] are forced to 0.
- `if_id_valid` out 1: IF/ID holds a live instruction.
- `if_id_pc` out PC_WIDTH: address of the IF/ID instruction.
- `if_id_instr` out 32: IF/ID instruction.
- `if_id_opcode` out 11: `if_id_instr[31:21]`, registered with it.

## Operation
- **Reset:** `pc`=RESET_PC; `imem_req`=0; `imem_addr`=RESET_PC; `if_id_valid`=0; `if_id_pc`/`if_id_instr`/`if_id_opcode`=0; skid buffer empty; state IDLE.
- **States:**
  - IDLE: exits to FETCH on the first cycle out of reset.
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - HOLD: fetched word parked in the skid buffer; `imem_req`=0.
  - DISCARD: redirect pending behind an outstanding request; `imem_req`=1 at the old address.
- **FETCH, on completion:**
  - IF/ID free (`!stall` or `!if_id_valid`): load IF/ID and advance `pc` to the next PC. Issue the next request in the following cycle with no bubble, so zero-wait memory sustains 1 instruction/cycle.
  - Otherwise: write the skid buffer and go to HOLD.
- **HOLD:** on the first cycle with `stall`=0, the skid buffer moves to IF/ID and the state returns to FETCH.
- **Next PC:** `pc+4`, modulo 2^PC_WIDTH; wrap-around is not an error.
- **Stall:** `stall` with `if_id_valid`=1 freezes all `if_id_*` outputs. With `if_id_valid`=0, `stall` is ignored.
- **Redirect** (`branch_taken`=1):
  - `pc` <= target; `if_id_valid` <= 0, even under stall; skid buffer cleared.
  - Request outstanding without ack this cycle: go to DISCARD, keep `imem_req`/`imem_addr` unchanged until ack, drop that data, then FETCH at the target.
  - Ack in the same cycle as the redirect: drop the data and request the target next cycle.
  - In HOLD or IDLE: FETCH at the target next cycle.
- **Priority:** `rst` > `branch_taken` > `stall`.
- **Address stability:** `imem_addr` never changes while a request is unacknowledged.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Ack at edge N: `if_id_valid`=1 after edge N; next `imem_req` at the new address in cycle N+1.
- Redirect at edge N with no outstanding request: `imem_addr`=target after edge N.
- Redirect at edge N during DISCARD: the target request starts the cycle after the old ack.
- `rst` asserted mid-transaction abandons the request immediately. The memory is assumed to drop any pending ack when `imem_req` falls during reset.

## Configuration
- Macro: `FETCH_EARLY_B_EN`.
- **Defined:** a completed word with `[31:26]`=6'b000101 (B) sets next PC = `pc + (sign_extend(instr[25:0])<<2)` instead of `pc+4`. The B word is still delivered to IF/ID.
- **Undefined:** next PC is always `pc+4`, and B resolves later via `branch_taken`.

## Structure
- Shared `legv8_pkg` holds:
  - `INSTR_W`=32 and `OPCODE_W`=11;
  - `OP_B`=6'b000101;
  - the fetch state enum (IDLE/FETCH/HOLD/DISCARD).
- One sub-module, `fetch_pc_next`, computes `pc+4` and, when `FETCH_EARLY_B_EN` is defined, the B target. The FSM, skid buffer and IF/ID register stay in `fetch_stage`.

## Test plan
- **Reset release, zero-wait memory:** `imem_ack` tied 1, memory returns 0x8B020020 at 0 and 0xF8400041 at 4.
  - Addresses 0, 4, 8 on consecutive cycles.
  - `if_id_opcode`=0x458 then 0x7C2.
  - `if_id_pc` tracks the address.
- **3-cycle ack latency:** `imem_addr` is held for 3 cycles per fetch; `if_id_valid` pulses once per ack.
- **Stall 4 cycles with IF/ID valid:**
  - `if_id_*` frozen.
  - Next word parked in HOLD with `imem_req`=0.
  - On release, the parked word appears the next cycle with no loss or duplicate.
- **`branch_taken` with target 0x103:**
  - Fetch at 0x100.
  - `if_id_valid`=0 the next cycle.
  - Repeat with the redirect during an unacked request: the old address is held until ack, its data is dropped, then 0x100 is fetched.
- **PC wrap:** `RESET_PC`=2^64-4 fetches 0xFFFF_FFFF_FFFF_FFFC then 0.
- **`FETCH_EARLY_B_EN`:**
  - B with imm26=-2 at 0x40: next fetch at 0x38.
  - Without the macro: next fetch at 0x44.
